// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the CPU-to-device register bus bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sys_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] DEF_BASE = 32'h0000_7F00;

  // Register offsets inside each 16-byte device window
  localparam logic [3:0] CTRL   = 4'h0;
  localparam logic [3:0] PRESET = 4'h4;
  localparam logic [3:0] COUNT  = 4'h8;

  localparam int HWINT_W = 6;
  localparam int MAX_DEV = 6;
  localparam int IDX_W   = 3;

  // Only the three implemented word offsets are addressable
  function automatic logic legal_offset(input logic [3:0] off);
    return (off == CTRL) || (off == PRESET) || (off == COUNT);
  endfunction

endpackage

// File: rtl/sys_bridge_if.sv
// Bundles the CPU request/response port and the device register bus.
// Latency: n/a (wiring only).
// Backpressure: none; the CPU side sees a fixed-latency response strobe.
interface sys_bridge_if #(
  parameter int NDEV = 3
);
  import sys_bridge_pkg::*;

  // CPU memory-stage side
  logic                 cpu_req;
  logic                 cpu_we;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [3:0]           cpu_be;
  logic                 cpu_ready;
  logic [31:0]          cpu_rdata;
  logic                 cpu_err;

  // Device register bus side
  logic [3:0]           dev_add;
  logic [31:0]          dev_dat;
  logic [NDEV-1:0]      dev_we;
  logic [NDEV*32-1:0]   dev_rdat;
  logic [NDEV-1:0]      dev_irq;
  logic [HWINT_W-1:0]   hw_int;

  // Bridge view: responds to the CPU, initiates on the device bus
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output cpu_ready, cpu_rdata, cpu_err,
    output dev_add, dev_dat, dev_we,
    input  dev_rdat, dev_irq,
    output hw_int
  );

  // Environment view: CPU pipeline plus attached devices
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  cpu_ready, cpu_rdata, cpu_err,
    input  dev_add, dev_dat, dev_we,
    output dev_rdat, dev_irq,
    input  hw_int
  );

endinterface

// File: rtl/sys_bridge_decode.sv
// Address decoder: splits a CPU address into device index, register offset and fault flag.
// Latency: combinational.
// Backpressure: none.
module sys_bridge_decode
  import sys_bridge_pkg::*;
#(
  parameter int          NDEV = 3,
  parameter logic [31:0] BASE = DEF_BASE
) (
  input  logic [31:0]      cpu_addr,
  input  logic             cpu_we,
  input  logic [3:0]       cpu_be,
  output logic [IDX_W-1:0] index,
  output logic [3:0]       offset,
  output logic             fault
);

  logic [31:0] rel;
  logic        in_range;

  // Window-relative address; only meaningful when cpu_addr >= BASE
  assign rel      = cpu_addr - BASE;
  assign in_range = (cpu_addr >= BASE) && (rel < 32'(16 * NDEV));
  assign index    = rel[IDX_W+3:4];
  assign offset   = cpu_addr[3:0];

  // Any violation turns the access into an error response with no side effect
  always_comb begin
    fault = 1'b0;
    if (!in_range)                     fault = 1'b1;
    if (cpu_addr[1:0] != 2'b00)        fault = 1'b1;
    if (!legal_offset(cpu_addr[3:0]))  fault = 1'b1;
    if (cpu_be != 4'hF)                fault = 1'b1;
    if (cpu_we && (cpu_addr[3:0] == COUNT)) fault = 1'b1;
  end

endmodule

// File: rtl/sys_bridge.sv
// CPU initiator for the timer register bus, plus registered interrupt vector to CP0.
// Latency: request at edge n -> dev_we in cycle n+1 -> cpu_ready in cycle n+2.
// Backpressure: none; requests arriving outside IDLE are dropped, never queued.
module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int          NDEV = 3,
  parameter logic [31:0] BASE = DEF_BASE
) (
  input  logic         clk,
  input  logic         reset,
  sys_bridge_if.master bus
);

  state_t               state, next_state;

  logic                 we_q;
  logic                 fault_q;
  logic [IDX_W-1:0]     idx_q;
  logic [3:0]           off_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic [HWINT_W-1:0]   hw_int_q;

  logic [IDX_W-1:0]     dec_idx;
  logic [3:0]           dec_off;
  logic                 dec_fault;
  logic [31:0]          rd_sel;
  logic [HWINT_W-1:0]   irq_ext;
  logic [NDEV-1:0]      we_vec;

  sys_bridge_decode #(
    .NDEV (NDEV),
    .BASE (BASE)
  ) u_decode (
    .cpu_addr (bus.cpu_addr),
    .cpu_we   (bus.cpu_we),
    .cpu_be   (bus.cpu_be),
    .index    (dec_idx),
    .offset   (dec_off),
    .fault    (dec_fault)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state: one access walks IDLE -> ACCESS -> RESP -> IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.cpu_req) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the request only when accepted in IDLE; also drives dev_add/dev_dat
  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      idx_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
    end else if ((state == IDLE) && bus.cpu_req) begin
      we_q    <= bus.cpu_we;
      fault_q <= dec_fault;
      idx_q   <= dec_idx;
      off_q   <= dec_off;
      wdata_q <= bus.cpu_wdata;
    end
  end

  // Select the addressed device's read word (index is in range whenever it is used)
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (idx_q == IDX_W'(i)) rd_sel = bus.dev_rdat[i*32 +: 32];
    end
  end

  // Capture load data at the end of ACCESS; stores and faults return zero
  always_ff @(posedge clk) begin
    if (!reset)                rdata_q <= '0;
    else if (state == ACCESS)  rdata_q <= (we_q || fault_q) ? 32'h0 : rd_sel;
  end

  // Zero-extend device interrupts to the CP0 vector width
  always_comb begin
    irq_ext = '0;
    for (int i = 0; i < NDEV; i++) irq_ext[i] = bus.dev_irq[i];
  end

  // One register stage on the interrupt lines
  always_ff @(posedge clk) begin
    if (!reset) hw_int_q <= '0;
    else        hw_int_q <= irq_ext;
  end

  // Outputs: write strobe gated by live reset so a reset mid-access never writes
  always_comb begin
    we_vec        = '0;
    bus.cpu_ready = 1'b0;
    bus.cpu_err   = 1'b0;
    if ((state == ACCESS) && we_q && !fault_q && reset) begin
      for (int i = 0; i < NDEV; i++) begin
        if (idx_q == IDX_W'(i)) we_vec[i] = 1'b1;
      end
    end
    if (state == RESP) begin
      bus.cpu_ready = 1'b1;
      bus.cpu_err   = fault_q;
    end
  end

  assign bus.dev_we    = we_vec;
  assign bus.cpu_rdata = rdata_q;
  assign bus.dev_add   = off_q;
  assign bus.dev_dat   = wdata_q;
  assign bus.hw_int    = hw_int_q;

endmodule

// File: tb/tb_sys_bridge.sv
// Self-checking bench for sys_bridge: directed cases then random accesses vs a behavioural model.
// Latency: checks the fixed 2-cycle request-to-response timing.
// Backpressure: none on the bridge; the bench also probes dropped requests.
module tb_sys_bridge;
  import sys_bridge_pkg::*;

  localparam int          NDEV = 3;
  localparam logic [31:0] BASE = DEF_BASE;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  sys_bridge_if #(.NDEV(NDEV)) bus ();

  sys_bridge #(
    .NDEV (NDEV),
    .BASE (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- device model ----------------
  logic [31:0] dregs  [NDEV][3];
  logic [31:0] shadow [NDEV][3];

  function automatic logic [31:0] init_val(input int i, input int k);
    if (i == 1 && k == 1) return 32'h0000_0064;
    return 32'hC0DE_0000 | 32'(i << 8) | 32'(k);
  endfunction

  // Devices reset with the system and accept writes at any implemented offset
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NDEV; i++)
        for (int k = 0; k < 3; k++) dregs[i][k] <= init_val(i, k);
    end else begin
      for (int i = 0; i < NDEV; i++)
        if (bus.dev_we[i] && bus.dev_add[1:0] == 2'b00 && bus.dev_add[3:2] != 2'd3)
          dregs[i][int'(bus.dev_add[3:2])] <= bus.dev_dat;
    end
  end

  // Combinational read data as a function of dev_add
  always_comb begin
    bus.dev_rdat = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (bus.dev_add[1:0] == 2'b00 && bus.dev_add[3:2] != 2'd3)
        bus.dev_rdat[i*32 +: 32] = dregs[i][int'(bus.dev_add[3:2])];
      else
        bus.dev_rdat[i*32 +: 32] = 32'hDEAD_BEEF;
    end
  end

  // ---------------- reference model ----------------
  task automatic reset_shadow();
    for (int i = 0; i < NDEV; i++)
      for (int k = 0; k < 3; k++) shadow[i][k] = init_val(i, k);
  endtask

  function automatic logic ref_fault(input logic we, input logic [31:0] a, input logic [3:0] be);
    longint lo, hi, rel;
    lo  = longint'(BASE);
    hi  = lo + 16 * NDEV;
    rel = longint'(a) - lo;
    if (longint'(a) < lo || longint'(a) >= hi) return 1'b1;
    if (a % 4 != 0) return 1'b1;
    if (!(rel % 16 == 0 || rel % 16 == 4 || rel % 16 == 8)) return 1'b1;
    if (be != 4'hF) return 1'b1;
    if (we && rel % 16 == 8) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full access; checks strobe cycle and response cycle against the model
  task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    logic            f;
    int              idx, k;
    logic [NDEV-1:0] exp_we;
    logic [31:0]     exp_rd;
    f      = ref_fault(we, addr, be);
    idx    = 0;
    k      = 0;
    exp_we = '0;
    exp_rd = 32'h0;
    if (!f) begin
      idx = int'((addr - BASE) / 16);
      k   = int'(((addr - BASE) % 16) / 4);
      if (we) exp_we[idx] = 1'b1;
      else    exp_rd = shadow[idx][k];
    end
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    chk({tag, ":acc_we"},    32'(bus.dev_we), 32'(exp_we));
    chk({tag, ":acc_add"},   32'(bus.dev_add), 32'(addr[3:0]));
    chk({tag, ":acc_dat"},   bus.dev_dat, wdata);
    chk({tag, ":acc_ready"}, 32'(bus.cpu_ready), 32'h0);
    if (!f && we) shadow[idx][k] = wdata;
    @(negedge clk);
    chk({tag, ":rsp_ready"}, 32'(bus.cpu_ready), 32'h1);
    chk({tag, ":rsp_err"},   32'(bus.cpu_err), 32'(f));
    chk({tag, ":rsp_rdata"}, bus.cpu_rdata, exp_rd);
    chk({tag, ":rsp_we"},    32'(bus.dev_we), 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  irq;
    logic [31:0] a;
    logic        w;
    logic [3:0]  be;

    reset         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    bus.cpu_be    = 4'h0;
    bus.dev_irq   = '0;
    reset_shadow();
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(bus.cpu_ready), 32'h0);
    chk("rst_err",   32'(bus.cpu_err), 32'h0);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_add",   32'(bus.dev_add), 32'h0);
    chk("rst_dat",   bus.dev_dat, 32'h0);
    chk("rst_we",    32'(bus.dev_we), 32'h0);
    chk("rst_hwint", 32'(bus.hw_int), 32'h0);
    reset = 1'b1;

    // Directed store and load
    do_access("st_ctrl0", 1'b1, 32'h0000_7F00, 32'h0000_0009, 4'hF);
    do_access("ld_dev1",  1'b0, 32'h0000_7F14, 32'h0, 4'hF);
    chk("ld_dev1_val", bus.cpu_rdata, 32'h0000_0064);

    // Faults
    do_access("f_st_count", 1'b1, 32'h0000_7F08, 32'h1234_5678, 4'hF);
    do_access("f_range",    1'b0, 32'h0000_7F30, 32'h0, 4'hF);
    do_access("f_be",       1'b1, 32'h0000_7F00, 32'hAAAA_5555, 4'h3);
    do_access("f_align",    1'b0, 32'h0000_7F02, 32'h0, 4'hF);
    do_access("f_below",    1'b0, 32'h0000_7EFC, 32'h0, 4'hF);
    do_access("f_off12",    1'b0, 32'h0000_7F0C, 32'h0, 4'hF);

    // Requests during ACCESS and RESP are dropped
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h0000_7F04;
    bus.cpu_be   = 4'hF;
    @(negedge clk);
    bus.cpu_addr = 32'h0000_7F20;
    bus.cpu_we   = 1'b1;
    chk("drop_acc_ready", 32'(bus.cpu_ready), 32'h0);
    @(negedge clk);
    chk("drop_rsp_ready", 32'(bus.cpu_ready), 32'h1);
    chk("drop_rsp_rdata", bus.cpu_rdata, shadow[0][1]);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    chk("drop_idle_ready", 32'(bus.cpu_ready), 32'h0);
    chk("drop_idle_we",    32'(bus.dev_we), 32'h0);
    @(negedge clk);
    chk("drop_late_ready", 32'(bus.cpu_ready), 32'h0);
    chk("drop_late_we",    32'(bus.dev_we), 32'h0);
    @(negedge clk);
    chk("drop_late2_ready", 32'(bus.cpu_ready), 32'h0);

    // Interrupt register: one edge of delay each way
    @(negedge clk);
    bus.dev_irq = 3'b101;
    chk("irq_before", 32'(bus.hw_int), 32'h0);
    @(negedge clk);
    chk("irq_set", 32'(bus.hw_int), 32'b000101);
    bus.dev_irq = 3'b000;
    @(negedge clk);
    chk("irq_clr", 32'(bus.hw_int), 32'h0);

    // Randomized accesses against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = BASE + 32'($urandom_range(0, 63));
        default: a = BASE + 32'($urandom_range(0, NDEV - 1) * 16) + 32'($urandom_range(0, 2) * 4);
      endcase
      w  = 1'($urandom_range(0, 1));
      be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      do_access("rnd", w, a, $urandom, be);
      irq = 3'($urandom);
      @(negedge clk);
      bus.dev_irq = irq;
      @(negedge clk);
      chk("rnd_irq", 32'(bus.hw_int), 32'({3'b000, irq}));
    end
    bus.dev_irq = '0;

    // Reset asserted in the ACCESS cycle of a store
    do_access("pre_rst_ld", 1'b0, 32'h0000_7F24, 32'h0, 4'hF);
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'h0000_7F10;
    bus.cpu_wdata = 32'h0000_0055;
    bus.cpu_be    = 4'hF;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    reset       = 1'b0;
    #1;
    chk("rstacc_we",    32'(bus.dev_we), 32'h0);
    chk("rstacc_ready", 32'(bus.cpu_ready), 32'h0);
    @(negedge clk);
    chk("rstacc_ready2", 32'(bus.cpu_ready), 32'h0);
    chk("rstacc_err",    32'(bus.cpu_err), 32'h0);
    chk("rstacc_rdata",  bus.cpu_rdata, 32'h0);
    chk("rstacc_add",    32'(bus.dev_add), 32'h0);
    chk("rstacc_dat",    bus.dev_dat, 32'h0);
    chk("rstacc_we2",    32'(bus.dev_we), 32'h0);
    chk("rstacc_hwint",  32'(bus.hw_int), 32'h0);
    reset = 1'b1;
    reset_shadow();
    @(negedge clk);
    chk("rstacc_ready3", 32'(bus.cpu_ready), 32'h0);
    chk("rstacc_we3",    32'(bus.dev_we), 32'h0);
    do_access("post_rst_ld", 1'b0, 32'h0000_7F10, 32'h0, 4'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
